alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Integer execution unit at the far end of the reservation-station dispatch interface.
- Consumes one dispatched op per cycle (enable, op, Vj, Vk, Imm, DestRob, CurPC) and computes the result.
- Broadcasts {valid, RobId, value} on the common data bus consumed by RS, LSB and ROB.
- Also resolves branches and jumps for the ROB. An optional iterative multiply/divide path adds a busy back-pressure.

Parameters:
- OP_W, 6, width of op field; op encodings are the shared op list in config.v.
- ROB_W, 4, width of ROB index.
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rdy  in  1  global ready; low freezes unit
- rollback  in  1  ROB misprediction flush
- in_valid  in  1  dispatch strobe from RS
- in_op  in  OP_W  operation
- in_vj  in  XLEN  operand 1
- in_vk  in  XLEN  operand 2
- in_imm  in  XLEN  immediate
- in_dest_rob  in  ROB_W  destination ROB entry
- in_cur_pc  in  XLEN  instruction PC
- busy  out  1  unit cannot accept in_valid this cycle
- out_valid  out  1  CDB broadcast strobe
- out_rob_id  out  ROB_W  tag being broadcast
- out_value  out  XLEN  result value
- out_jump  out  1  branch/jump taken
- out_target_pc  out  XLEN  resolved target PC

Behaviour:
- Reset: rst synchronous, active-high; clock clk.
  - All outputs 0; muldiv FSM goes to IDLE.
- rdy=0:
  - All state held; out_valid driven 0 that cycle.
  - An in_valid presented while rdy=0 is ignored; RS never asserts enable then.
- rollback=1 (rdy=1):
  - Next cycle out_valid=0.
  - In-flight muldiv aborted to IDLE; busy=0.
  - Same-cycle in_valid is dropped.
- Base ops, 1-cycle latency: in_valid in cycle N gives a registered result with out_valid=1 in N+1, for exactly one cycle.
- Arithmetic and logic:
  - ADD/SUB/AND/OR/XOR/SLT/SLTU/SLL/SRL/SRA on (vj, vk).
  - I-forms use imm in place of vk.
  - Shift amount is the low 5 bits; SLT is signed, SLTU unsigned.
  - All arithmetic wraps mod 2^32.
- LUI: value=imm. AUIPC: value=pc+imm.
- JAL: value=pc+4, jump=1, target=pc+imm.
- JALR: value=pc+4, jump=1, target=(vj+imm)&~1.
- Branches BEQ/BNE/BLT/BGE/BLTU/BGEU:
  - value=0; jump=condition.
  - target = pc+imm if taken, else pc+4.
- Non-branch, non-jump ops: jump=0, target=pc+4.
- Unknown op: out_valid=1, value=0, jump=0.
- busy is 0 whenever no muldiv is in flight.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: adds MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with FSM IDLE -> RUN -> DONE -> IDLE.
  - Accept in cycle N: busy=1 from N+1 through the DONE cycle.
  - 32 shift-add/shift-subtract iterations, one per cycle.
  - Result broadcast in N+34 (out_valid one cycle); busy=0 the same cycle.
  - Operands are sign-converted on entry; result sign is fixed up in DONE.
  - Divide by zero: quotient=0xFFFFFFFF, remainder=dividend.
  - Overflow 0x80000000 / -1: quotient=0x80000000, remainder=0.
  - A base op dispatched while busy=1 is a protocol violation; no defined response.
- Undefined: M ops are treated as unknown ops (1-cycle, value 0); busy tied 0; no FSM logic.

Test Plan:
- ADD vj=0x7FFFFFFF vk=1 rob=3 -> next cycle out_valid=1, rob_id=3, value=0x80000000, jump=0.
- SRA vj=0x80000000 vk=0x24 -> value=0xF8000000 (shift 4). SLTU vj=1 vk=0xFFFFFFFF -> value=1.
- BLT vj=-1 vk=0 pc=0x100 imm=0x20 -> jump=1, target=0x120. Same operands with BGE -> jump=0, target=0x104.
- JALR vj=0x1003 imm=4 pc=0x200 -> value=0x204, target=0x1006, jump=1.
- ALU_MULDIV_EN: DIV vj=-7 vk=2 rob=5 -> busy for 33 cycles, value=0xFFFFFFFD at N+34. DIV by 0 -> 0xFFFFFFFF. REM vj=0x80000000 vk=-1 -> 0.
- Mid-DIV rollback -> busy=0 next cycle, no broadcast for that rob. rdy=0 for 3 cycles mid-MUL -> completion slips by 3 cycles.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: integer execute stage that resolves branches/jumps and broadcasts results on the CDB.
// Define ALU_MULDIV_EN to add the iterative MUL/DIV path with busy back-pressure.
module alu_exec_unit #(
    parameter int OP_W  = 6,
    parameter int ROB_W = 4,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback,
    input  logic             in_valid,
    input  logic [OP_W-1:0]  in_op,
    input  logic [XLEN-1:0]  in_vj,
    input  logic [XLEN-1:0]  in_vk,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [ROB_W-1:0] in_dest_rob,
    input  logic [XLEN-1:0]  in_cur_pc,
    output logic             busy,
    output logic             out_valid,
    output logic [ROB_W-1:0] out_rob_id,
    output logic [XLEN-1:0]  out_value,
    output logic             out_jump,
    output logic [XLEN-1:0]  out_target_pc
);
    localparam int SH_W = $clog2(XLEN);

    localparam logic [OP_W-1:0] OP_ADD    = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB    = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_OR     = OP_W'(4);
    localparam logic [OP_W-1:0] OP_XOR    = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SLT    = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SLTU   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SLL    = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SRL    = OP_W'(9);
    localparam logic [OP_W-1:0] OP_SRA    = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ADDI   = OP_W'(11);
    localparam logic [OP_W-1:0] OP_ANDI   = OP_W'(12);
    localparam logic [OP_W-1:0] OP_ORI    = OP_W'(13);
    localparam logic [OP_W-1:0] OP_XORI   = OP_W'(14);
    localparam logic [OP_W-1:0] OP_SLTI   = OP_W'(15);
    localparam logic [OP_W-1:0] OP_SLTIU  = OP_W'(16);
    localparam logic [OP_W-1:0] OP_SLLI   = OP_W'(17);
    localparam logic [OP_W-1:0] OP_SRLI   = OP_W'(18);
    localparam logic [OP_W-1:0] OP_SRAI   = OP_W'(19);
    localparam logic [OP_W-1:0] OP_LUI    = OP_W'(20);
    localparam logic [OP_W-1:0] OP_AUIPC  = OP_W'(21);
    localparam logic [OP_W-1:0] OP_JAL    = OP_W'(22);
    localparam logic [OP_W-1:0] OP_JALR   = OP_W'(23);
    localparam logic [OP_W-1:0] OP_BEQ    = OP_W'(24);
    localparam logic [OP_W-1:0] OP_BNE    = OP_W'(25);
    localparam logic [OP_W-1:0] OP_BLT    = OP_W'(26);
    localparam logic [OP_W-1:0] OP_BGE    = OP_W'(27);
    localparam logic [OP_W-1:0] OP_BLTU   = OP_W'(28);
    localparam logic [OP_W-1:0] OP_BGEU   = OP_W'(29);
    localparam logic [OP_W-1:0] OP_MUL    = OP_W'(30);
    localparam logic [OP_W-1:0] OP_MULH   = OP_W'(31);
    localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(32);
    localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(33);
    localparam logic [OP_W-1:0] OP_DIV    = OP_W'(34);
    localparam logic [OP_W-1:0] OP_DIVU   = OP_W'(35);
    localparam logic [OP_W-1:0] OP_REM    = OP_W'(36);
    localparam logic [OP_W-1:0] OP_REMU   = OP_W'(37);

    logic             is_imm, is_br;
    logic [XLEN-1:0]  opb, pc4, br_tgt, res_val, res_tgt;
    logic [SH_W-1:0]  shamt;
    logic             res_jump;

    assign is_imm = in_op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU,
                                  OP_SLLI, OP_SRLI, OP_SRAI};
    assign is_br  = in_op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    assign opb    = is_imm ? in_imm : in_vk;
    assign shamt  = opb[SH_W-1:0];
    assign pc4    = in_cur_pc + XLEN'(4);
    assign br_tgt = in_cur_pc + in_imm;

    always_comb begin
        res_val  = '0;
        res_jump = 1'b0;
        res_tgt  = pc4;
        case (in_op)
            OP_ADD, OP_ADDI:   res_val = in_vj + opb;
            OP_SUB:            res_val = in_vj - in_vk;
            OP_AND, OP_ANDI:   res_val = in_vj & opb;
            OP_OR, OP_ORI:     res_val = in_vj | opb;
            OP_XOR, OP_XORI:   res_val = in_vj ^ opb;
            OP_SLT, OP_SLTI:   res_val = XLEN'($signed(in_vj) < $signed(opb));
            OP_SLTU, OP_SLTIU: res_val = XLEN'(in_vj < opb);
            OP_SLL, OP_SLLI:   res_val = in_vj << shamt;
            OP_SRL, OP_SRLI:   res_val = in_vj >> shamt;
            OP_SRA, OP_SRAI:   res_val = $unsigned($signed(in_vj) >>> shamt);
            OP_LUI:            res_val = in_imm;
            OP_AUIPC:          res_val = br_tgt;
            OP_JAL: begin
                res_val  = pc4;
                res_jump = 1'b1;
                res_tgt  = br_tgt;
            end
            OP_JALR: begin
                res_val  = pc4;
                res_jump = 1'b1;
                res_tgt  = (in_vj + in_imm) & ~XLEN'(1);
            end
            OP_BEQ:            res_jump = in_vj == in_vk;
            OP_BNE:            res_jump = in_vj != in_vk;
            OP_BLT:            res_jump = $signed(in_vj) < $signed(in_vk);
            OP_BGE:            res_jump = $signed(in_vj) >= $signed(in_vk);
            OP_BLTU:           res_jump = in_vj < in_vk;
            OP_BGEU:           res_jump = in_vj >= in_vk;
            default:           res_val = '0;
        endcase
        if (is_br && res_jump)
            res_tgt = br_tgt;
    end

    logic             m_op, m_done;
    logic [XLEN-1:0]  m_res, m_pc4;
    logic [ROB_W-1:0] m_rob;

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t           state_q;
    logic [SH_W-1:0]  cnt_q;
    logic [XLEN-1:0]  hi_q, lo_q, dvs_q, pc4_q;
    logic [ROB_W-1:0] rob_m_q;
    logic             div_q, sel_q, neg_q;

    logic             a_neg, b_neg, m_div, m_sel, m_neg;
    logic [XLEN-1:0]  a_mag, b_mag, step_hi, step_lo, dsel, dfix;
    logic [XLEN:0]    msum, dt, ddiff;
    logic [2*XLEN-1:0] prod;

    assign m_op  = in_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign m_div = in_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign m_sel = in_op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
    assign a_neg = (in_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & in_vj[XLEN-1];
    assign b_neg = (in_op inside {OP_MULH, OP_DIV, OP_REM}) & in_vk[XLEN-1];
    assign a_mag = a_neg ? -in_vj : in_vj;
    assign b_mag = b_neg ? -in_vk : in_vk;
    // A zero divisor must yield all-ones quotient regardless of dividend sign.
    assign m_neg = m_div ? (m_sel ? a_neg : (a_neg ^ b_neg) & (|in_vk)) : a_neg ^ b_neg;

    assign msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    assign dt    = {hi_q, lo_q[XLEN-1]};
    assign ddiff = dt - {1'b0, dvs_q};
    assign step_hi = div_q ? (dt >= {1'b0, dvs_q} ? ddiff[XLEN-1:0] : dt[XLEN-1:0]) : msum[XLEN:1];
    assign step_lo = div_q ? {lo_q[XLEN-2:0], dt >= {1'b0, dvs_q}} : {msum[0], lo_q[XLEN-1:1]};

    assign prod   = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign dsel   = sel_q ? hi_q : lo_q;
    assign dfix   = neg_q ? -dsel : dsel;
    assign m_res  = div_q ? dfix : (sel_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]);
    assign m_done = state_q == S_DONE;
    assign m_pc4  = pc4_q;
    assign m_rob  = rob_m_q;
    assign busy   = state_q != S_IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else if (rdy) begin
            if (rollback)
                state_q <= S_IDLE;
            else case (state_q)
                S_IDLE: if (in_valid && m_op) begin
                    state_q <= S_RUN;
                    cnt_q   <= '0;
                    hi_q    <= '0;
                    lo_q    <= m_div ? a_mag : b_mag;
                    dvs_q   <= m_div ? b_mag : a_mag;
                    div_q   <= m_div;
                    sel_q   <= m_sel;
                    neg_q   <= m_neg;
                    rob_m_q <= in_dest_rob;
                    pc4_q   <= pc4;
                end
                S_RUN: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q + SH_W'(1);
                    if (cnt_q == SH_W'(XLEN - 1))
                        state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
`else
    assign m_op   = 1'b0;
    assign m_done = 1'b0;
    assign m_res  = '0;
    assign m_pc4  = '0;
    assign m_rob  = '0;
    assign busy   = 1'b0;
`endif

    logic             valid_q, jump_q;
    logic [ROB_W-1:0] rob_q;
    logic [XLEN-1:0]  value_q, tgt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            rob_q   <= '0;
            value_q <= '0;
            jump_q  <= 1'b0;
            tgt_q   <= '0;
        end else if (rdy) begin
            valid_q <= 1'b0;
            if (!rollback && m_done) begin
                valid_q <= 1'b1;
                rob_q   <= m_rob;
                value_q <= m_res;
                jump_q  <= 1'b0;
                tgt_q   <= m_pc4;
            end else if (!rollback && in_valid && !m_op) begin
                valid_q <= 1'b1;
                rob_q   <= in_dest_rob;
                value_q <= res_val;
                jump_q  <= res_jump;
                tgt_q   <= res_tgt;
            end
        end
    end

    // A held result is hidden while the pipeline is frozen.
    assign out_valid     = valid_q & rdy;
    assign out_rob_id    = rob_q;
    assign out_value     = value_q;
    assign out_jump      = jump_q;
    assign out_target_pc = tgt_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit.
module tb_alu_exec_unit;
    localparam logic [5:0] OP_ADD = 1, OP_SUB = 2, OP_AND = 3, OP_OR = 4, OP_XOR = 5, OP_SLT = 6,
        OP_SLTU = 7, OP_SLL = 8, OP_SRL = 9, OP_SRA = 10, OP_ADDI = 11, OP_XORI = 14, OP_SLTI = 15,
        OP_SLTIU = 16, OP_SRAI = 19, OP_LUI = 20, OP_AUIPC = 21, OP_JAL = 22, OP_JALR = 23,
        OP_BEQ = 24, OP_BNE = 25, OP_BLT = 26, OP_BGE = 27, OP_BLTU = 28, OP_BGEU = 29,
        OP_MUL = 30, OP_MULH = 31, OP_MULHSU = 32, OP_MULHU = 33, OP_DIV = 34, OP_REM = 36,
        OP_BAD = 63;

    localparam logic [5:0]  AV_OP [17] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU,
        OP_SLL, OP_SRL, OP_SRA, OP_ADDI, OP_XORI, OP_SLTI, OP_SRAI, OP_LUI, OP_AUIPC, OP_SLTIU};
    localparam logic [31:0] AV_VJ [17] = '{32'h7FFFFFFF, 32'd5, 32'hFF00FF00, 32'hF0, 32'hFFFF0000,
        32'd1, 32'd1, 32'd1, 32'h80000000, 32'h80000000, 32'd10, 32'hF0F0, 32'hFFFFFFFF,
        32'h80000000, 32'd0, 32'd0, 32'd5};
    localparam logic [31:0] AV_VK [17] = '{32'd1, 32'd7, 32'h0F0F0F0F, 32'h0F, 32'hFF00FF00,
        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h21, 32'h24, 32'h24, 32'd100, 32'd0, 32'd0, 32'd0, 32'd0,
        32'd0, 32'd0};
    localparam logic [31:0] AV_IMM [17] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
        32'd0, 32'd0, 32'hFFFFFFFD, 32'hFF, 32'd0, 32'd31, 32'h12345000, 32'h20, 32'hFFFFFFFF};
    localparam logic [31:0] AV_EXP [17] = '{32'h80000000, 32'hFFFFFFFE, 32'h0F000F00, 32'hFF,
        32'h00FFFF00, 32'd0, 32'd1, 32'd2, 32'h08000000, 32'hF8000000, 32'd7, 32'hF00F, 32'd1,
        32'hFFFFFFFF, 32'h12345000, 32'h60, 32'd1};

    localparam logic [5:0]  BV_OP [6] = '{OP_BLT, OP_BGE, OP_BEQ, OP_BNE, OP_BLTU, OP_BGEU};
    localparam logic [31:0] BV_VJ [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF};
    localparam logic [31:0] BV_VK [6] = '{32'd0, 32'd0, 32'd5, 32'd5, 32'd0, 32'd0};
    localparam logic        BV_J  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, in_valid;
    logic [5:0]  in_op;
    logic [31:0] in_vj, in_vk, in_imm, in_cur_pc;
    logic [3:0]  in_dest_rob;
    logic        busy, out_valid, out_jump;
    logic [3:0]  out_rob_id;
    logic [31:0] out_value, out_target_pc;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.OP_W(6), .ROB_W(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .in_valid(in_valid),
        .in_op(in_op), .in_vj(in_vj), .in_vk(in_vk), .in_imm(in_imm),
        .in_dest_rob(in_dest_rob), .in_cur_pc(in_cur_pc), .busy(busy),
        .out_valid(out_valid), .out_rob_id(out_rob_id), .out_value(out_value),
        .out_jump(out_jump), .out_target_pc(out_target_pc)
    );

    task automatic dispatch(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic [31:0] imm, input logic [3:0] rob, input logic [31:0] pc);
        @(negedge clk);
        in_op = op; in_vj = vj; in_vk = vk; in_imm = imm; in_dest_rob = rob; in_cur_pc = pc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; in_valid = 1'b0;
        in_op = '0; in_vj = '0; in_vk = '0; in_imm = '0; in_dest_rob = '0; in_cur_pc = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        dispatch(OP_JAL, 32'd0, 32'd0, 32'h40, 4'd9, 32'h300);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_rob_id !== 4'd0) begin errors++; $display("FAIL reset_rob: got %h expected 0", out_rob_id); end
        checks++; if (out_value !== 32'd0) begin errors++; $display("FAIL reset_value: got %h expected 0", out_value); end
        checks++; if (out_jump !== 1'b0) begin errors++; $display("FAIL reset_jump: got %b expected 0", out_jump); end
        checks++; if (out_target_pc !== 32'd0) begin errors++; $display("FAIL reset_target: got %h expected 0", out_target_pc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_arith;
        for (int i = 0; i < 17; i++) begin
            dispatch(AV_OP[i], AV_VJ[i], AV_VK[i], AV_IMM[i], 4'(i), 32'h40);
            checks++; if (out_valid !== 1'b1 || out_rob_id !== 4'(i)) begin errors++;
                $display("FAIL arith_valid[%0d]: got valid=%b rob=%h expected 1/%h", i, out_valid, out_rob_id, 4'(i)); end
            checks++; if (out_value !== AV_EXP[i]) begin errors++;
                $display("FAIL arith_value[%0d]: got %h expected %h", i, out_value, AV_EXP[i]); end
            checks++; if (out_jump !== 1'b0 || out_target_pc !== 32'h44) begin errors++;
                $display("FAIL arith_nojump[%0d]: got jump=%b target=%h expected 0/00000044", i, out_jump, out_target_pc); end
        end
    endtask

    task automatic test_branch;
        for (int i = 0; i < 6; i++) begin
            dispatch(BV_OP[i], BV_VJ[i], BV_VK[i], 32'h20, 4'd2, 32'h100);
            checks++; if (out_jump !== BV_J[i]) begin errors++;
                $display("FAIL branch_jump[%0d]: got %b expected %b", i, out_jump, BV_J[i]); end
            checks++; if (out_target_pc !== (BV_J[i] ? 32'h120 : 32'h104)) begin errors++;
                $display("FAIL branch_target[%0d]: got %h expected %h", i, out_target_pc, BV_J[i] ? 32'h120 : 32'h104); end
            checks++; if (out_value !== 32'd0 || out_valid !== 1'b1) begin errors++;
                $display("FAIL branch_value[%0d]: got value=%h valid=%b expected 0/1", i, out_value, out_valid); end
        end
    endtask

    task automatic test_jump;
        dispatch(OP_JALR, 32'h1003, 32'd0, 32'd4, 4'd6, 32'h200);
        checks++; if (out_value !== 32'h204 || out_target_pc !== 32'h1006 || out_jump !== 1'b1) begin errors++;
            $display("FAIL jalr: got value=%h target=%h jump=%b expected 00000204/00001006/1", out_value, out_target_pc, out_jump); end
        dispatch(OP_JAL, 32'd0, 32'd0, 32'h40, 4'd7, 32'h300);
        checks++; if (out_value !== 32'h304 || out_target_pc !== 32'h340 || out_jump !== 1'b1) begin errors++;
            $display("FAIL jal: got value=%h target=%h jump=%b expected 00000304/00000340/1", out_value, out_target_pc, out_jump); end
    endtask

    task automatic test_unknown;
        dispatch(OP_BAD, 32'h55, 32'h66, 32'h77, 4'd8, 32'h400);
        checks++; if (out_valid !== 1'b1 || out_value !== 32'd0 || out_jump !== 1'b0) begin errors++;
            $display("FAIL unknown_op: got valid=%b value=%h jump=%b expected 1/0/0", out_valid, out_value, out_jump); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        in_op = OP_ADD; in_vj = 32'd1; in_vk = 32'd2; in_dest_rob = 4'd1; in_cur_pc = 32'h10; in_valid = 1'b1;
        @(negedge clk);
        in_op = OP_SUB; in_vj = 32'd10; in_vk = 32'd4; in_dest_rob = 4'd2;
        checks++; if (out_valid !== 1'b1 || out_rob_id !== 4'd1 || out_value !== 32'd3) begin errors++;
            $display("FAIL b2b_first: got valid=%b rob=%h value=%h expected 1/1/00000003", out_valid, out_rob_id, out_value); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_rob_id !== 4'd2 || out_value !== 32'd6) begin errors++;
            $display("FAIL b2b_second: got valid=%b rob=%h value=%h expected 1/2/00000006", out_valid, out_rob_id, out_value); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse: got valid=%b expected 0", out_valid); end
    endtask

    task automatic test_rollback;
        @(negedge clk);
        in_op = OP_ADD; in_vj = 32'd1; in_vk = 32'd1; in_dest_rob = 4'd4; in_valid = 1'b1; rollback = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; rollback = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rollback_drop: got valid=%b expected 0", out_valid); end
    endtask

    task automatic test_rdy;
        @(negedge clk);
        in_op = OP_ADD; in_vj = 32'd1; in_vk = 32'd1; in_dest_rob = 4'd5; in_valid = 1'b1; rdy = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rdy_low_valid: got valid=%b expected 0", out_valid); end
        rdy = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rdy_ignored_op: got valid=%b expected 0", out_valid); end
        dispatch(OP_ADD, 32'd2, 32'd2, 32'd0, 4'd9, 32'h0);
        rdy = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rdy_gate: got valid=%b expected 0", out_valid); end
        @(negedge clk);
        rdy = 1'b1;
        repeat (2) @(negedge clk);
    endtask

`ifdef ALU_MULDIV_EN
    task automatic run_m(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [3:0] rob, input int stall_at, output int lat, output logic busy_ok);
        dispatch(op, vj, vk, 32'd0, rob, 32'h500);
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (lat == stall_at) rdy = 1'b0;
            if (lat == stall_at + 3) rdy = 1'b1;
            @(negedge clk);
            lat++;
        end
        rdy = 1'b1;
    endtask

    task automatic test_muldiv;
        int lat;
        logic bok;
        run_m(OP_DIV, 32'hFFFFFFF9, 32'd2, 4'd5, -10, lat, bok);
        checks++; if (lat !== 34 || bok !== 1'b1) begin errors++; $display("FAIL div_latency: got lat=%0d busy_ok=%b expected 34/1", lat, bok); end
        checks++; if (out_value !== 32'hFFFFFFFD || out_rob_id !== 4'd5) begin errors++;
            $display("FAIL div_value: got value=%h rob=%h expected fffffffd/5", out_value, out_rob_id); end
        checks++; if (busy !== 1'b0 || out_jump !== 1'b0 || out_target_pc !== 32'h504) begin errors++;
            $display("FAIL div_done: got busy=%b jump=%b target=%h expected 0/0/00000504", busy, out_jump, out_target_pc); end
        run_m(OP_DIV, 32'd100, 32'd0, 4'd1, -10, lat, bok);
        checks++; if (out_value !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_zero: got %h expected ffffffff", out_value); end
        run_m(OP_REM, 32'h80000000, 32'hFFFFFFFF, 4'd2, -10, lat, bok);
        checks++; if (out_value !== 32'd0) begin errors++; $display("FAIL rem_ovf: got %h expected 0", out_value); end
        run_m(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 4'd3, -10, lat, bok);
        checks++; if (out_value !== 32'h80000000) begin errors++; $display("FAIL div_ovf: got %h expected 80000000", out_value); end
        run_m(OP_REM, 32'hFFFFFFF9, 32'd2, 4'd4, -10, lat, bok);
        checks++; if (out_value !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_neg: got %h expected ffffffff", out_value); end
        run_m(OP_MUL, 32'd3, 32'hFFFFFFFC, 4'd6, -10, lat, bok);
        checks++; if (out_value !== 32'hFFFFFFF4) begin errors++; $display("FAIL mul: got %h expected fffffff4", out_value); end
        run_m(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6, -10, lat, bok);
        checks++; if (out_value !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu: got %h expected fffffffe", out_value); end
        run_m(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6, -10, lat, bok);
        checks++; if (out_value !== 32'd0) begin errors++; $display("FAIL mulh: got %h expected 0", out_value); end
        run_m(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6, -10, lat, bok);
        checks++; if (out_value !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu: got %h expected ffffffff", out_value); end
        run_m(OP_MUL, 32'd6, 32'd7, 4'd10, 10, lat, bok);
        checks++; if (lat !== 37 || out_value !== 32'd42) begin errors++;
            $display("FAIL mul_stall: got lat=%0d value=%h expected 37/0000002a", lat, out_value); end
        dispatch(OP_DIV, 32'd50, 32'd5, 32'd0, 4'd7, 32'h0);
        repeat (10) @(negedge clk);
        rollback = 1'b1;
        @(negedge clk);
        rollback = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rollback_busy: got %b expected 0", busy); end
        bok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) bok = 1'b0;
        end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL rollback_no_bcast: got broadcast=%b expected 0", ~bok); end
    endtask
`else
    task automatic test_muldiv;
        dispatch(OP_MUL, 32'd6, 32'd7, 32'd0, 4'd3, 32'h500);
        checks++; if (out_valid !== 1'b1 || out_value !== 32'd0 || busy !== 1'b0) begin errors++;
            $display("FAIL m_as_unknown: got valid=%b value=%h busy=%b expected 1/0/0", out_valid, out_value, busy); end
    endtask
`endif

    initial begin
        test_reset;
        test_arith;
        test_branch;
        test_jump;
        test_unknown;
        test_back_to_back;
        test_rollback;
        test_rdy;
        test_muldiv;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
